// File: rtl/pe_simd_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_simd_acc_if
// Description : Beat interface of the precision-configurable PE. It groups the
//               input beat (valid, mode, precision, clear, a, b, c) and the
//               result (valid, out, sat).
//               master = array controller, slave = PE.
// Ports       : i_valid, i_mode[1:0], i_prec_mode, i_acc_clear,
//               i_a[ACT_WIDTH], i_b[WGT_WIDTH], i_c[PE_OUT_WIDTH]  -> PE
//               o_valid, o_out[PE_OUT_WIDTH], o_sat                <- PE
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_simd_acc_if #(
  parameter int ACT_WIDTH    = 16,
  parameter int WGT_WIDTH    = 16,
  parameter int PE_OUT_WIDTH = 32
) ();
  logic                    i_valid;
  logic [1:0]              i_mode;
  logic                    i_prec_mode;
  logic                    i_acc_clear;
  logic [ACT_WIDTH-1:0]    i_a;
  logic [WGT_WIDTH-1:0]    i_b;
  logic [PE_OUT_WIDTH-1:0] i_c;
  logic                    o_valid;
  logic [PE_OUT_WIDTH-1:0] o_out;
  logic                    o_sat;

  modport master (
    output i_valid, i_mode, i_prec_mode, i_acc_clear, i_a, i_b, i_c,
    input  o_valid, o_out, o_sat
  );

  modport slave (
    input  i_valid, i_mode, i_prec_mode, i_acc_clear, i_a, i_b, i_c,
    output o_valid, o_out, o_sat
  );
endinterface
`default_nettype wire

// File: rtl/pe_simd_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_simd_acc
// Description : Precision-configurable processing element. Each beat issues
//               one signed multiply: either a full-width product or a LANES-way
//               packed dot product. The result is then combined as MULT, FMA
//               (+c) or ACC (local accumulator), and the output is saturated to
//               PE_OUT_WIDTH. The pipeline is product -> combine -> saturate, so
//               a beat captured at edge N is presented after edge N+2.
// Ports       : clk   - clock, rising edge
//               reset - synchronous, active-low
//               bus   - pe_simd_acc_if.slave (input beat and result)
// Revision    : 1.0 - initial release
// ============================================================================
module pe_simd_acc #(
  parameter int ACT_WIDTH    = 16,
  parameter int WGT_WIDTH    = 16,
  parameter int LANES        = 2,
  parameter int ACC_WIDTH    = 48,
  parameter int PE_OUT_WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pe_simd_acc_if.slave    bus
);

  localparam int c_AL  = ACT_WIDTH / LANES;
  localparam int c_WL  = WGT_WIDTH / LANES;
  localparam int c_LPW = c_AL + c_WL;
  localparam int c_PW  = ACT_WIDTH + WGT_WIDTH;

  localparam logic [1:0] c_MODE_MULT = 2'd0;
  localparam logic [1:0] c_MODE_FMA  = 2'd1;
  localparam logic [1:0] c_MODE_ACC  = 2'd2;

  // ---------------- stage 1: product ----------------
  // Operands are sign-extended to the product width, so the low bits of an
  // unsigned multiply equal the signed product.
  logic [c_PW-1:0]      w_a_full;
  logic [c_PW-1:0]      w_b_full;
  logic [c_PW-1:0]      w_full;
  logic [ACC_WIDTH-1:0] w_lane_ext [LANES];
  logic [ACC_WIDTH-1:0] w_packed;
  logic [ACC_WIDTH-1:0] w_prod;
  logic [1:0]           w_mode_n;

  assign w_a_full = {{WGT_WIDTH{bus.i_a[ACT_WIDTH-1]}}, bus.i_a};
  assign w_b_full = {{ACT_WIDTH{bus.i_b[WGT_WIDTH-1]}}, bus.i_b};
  assign w_full   = w_a_full * w_b_full;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [c_LPW-1:0] w_la;
      logic [c_LPW-1:0] w_lb;
      logic [c_LPW-1:0] w_lp;
      assign w_la = {{c_WL{bus.i_a[gi*c_AL + c_AL - 1]}}, bus.i_a[gi*c_AL +: c_AL]};
      assign w_lb = {{c_AL{bus.i_b[gi*c_WL + c_WL - 1]}}, bus.i_b[gi*c_WL +: c_WL]};
      assign w_lp = w_la * w_lb;
      assign w_lane_ext[gi] = {{(ACC_WIDTH - c_LPW){w_lp[c_LPW-1]}}, w_lp};
    end
  endgenerate

  always_comb begin
    w_packed = '0;
    for (int i = 0; i < LANES; i++) begin
      w_packed = w_packed + w_lane_ext[i];
    end
  end

  assign w_prod   = bus.i_prec_mode ? w_packed
                                    : {{(ACC_WIDTH - c_PW){w_full[c_PW-1]}}, w_full};
  // The reserved encoding behaves as MULT, so normalise it once at the input.
  assign w_mode_n = (bus.i_mode == 2'd3) ? c_MODE_MULT : bus.i_mode;

  logic                    r_s1_valid;
  logic [1:0]              r_s1_mode;
  logic                    r_s1_clear;
  logic [PE_OUT_WIDTH-1:0] r_s1_c;
  logic [ACC_WIDTH-1:0]    r_s1_prod;

  // ---------------- stage 2: combine ----------------
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_c_ext;

  assign w_c_ext = {{(ACC_WIDTH - PE_OUT_WIDTH){r_s1_c[PE_OUT_WIDTH-1]}}, r_s1_c};

  always_comb begin
    w_sum = r_s1_prod;
    case (r_s1_mode)
      c_MODE_FMA: w_sum = r_s1_prod + w_c_ext;
      c_MODE_ACC: w_sum = (r_s1_clear ? '0 : r_acc) + r_s1_prod;
      default:    w_sum = r_s1_prod;
    endcase
  end

  logic                 r_s2_valid;
  logic [ACC_WIDTH-1:0] r_s2_sum;

  // ---------------- stage 3: saturate ----------------
  // The sum fits in PE_OUT_WIDTH exactly when all bits from the output sign
  // bit upward agree.
  logic [ACC_WIDTH-PE_OUT_WIDTH:0] w_hi;
  logic                            w_in_range;
  logic                            w_sign;
  logic [PE_OUT_WIDTH-1:0]         w_clip;

  assign w_hi       = r_s2_sum[ACC_WIDTH-1:PE_OUT_WIDTH-1];
  assign w_in_range = (&w_hi) | (~|w_hi);
  assign w_sign     = r_s2_sum[ACC_WIDTH-1];
  assign w_clip     = {w_sign, {(PE_OUT_WIDTH-1){~w_sign}}};

  logic                    r_out_valid;
  logic [PE_OUT_WIDTH-1:0] r_out;
  logic                    r_sat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= c_MODE_MULT;
      r_s1_clear  <= 1'b0;
      r_s1_c      <= '0;
      r_s1_prod   <= '0;
      r_acc       <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sum    <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_s1_mode  <= w_mode_n;
        r_s1_clear <= bus.i_acc_clear;
        r_s1_c     <= bus.i_c;
        r_s1_prod  <= w_prod;
      end

      // The accumulator is written here, one edge before the next beat's
      // combine, so back-to-back ACC beats chain without forwarding.
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum <= w_sum;
        if (r_s1_mode == c_MODE_ACC) begin
          r_acc <= w_sum;
        end
      end

      // out/sat hold their value through bubbles.
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out <= w_in_range ? r_s2_sum[PE_OUT_WIDTH-1:0] : w_clip;
        r_sat <= ~w_in_range;
      end
    end
  end

  assign bus.o_valid = r_out_valid;
  assign bus.o_out   = r_out;
  assign bus.o_sat   = r_sat;

endmodule
`default_nettype wire

// File: doc/pe_simd_acc.md
# pe_simd_acc

Next-generation precision-configurable processing element for the systolic array. It issues a signed multiply every cycle, either one full-width product or a LANES-way packed dot product. It then combines the result in one of three modes: plain multiply, fused multiply-add with the incoming partial sum, or local accumulation. The result is saturated to the output width. A valid handshake and a fixed 2-cycle pipeline let the array controller insert bubbles without corrupting accumulator state.

## Interface
- ACT_WIDTH, 16: activation width; must be divisible by LANES.
- WGT_WIDTH, 16: weight width; must be divisible by LANES.
- LANES, 2: number of sub-word lanes in packed mode.
- ACC_WIDTH, 48: internal sum/accumulator width; must be ≥ ACT_WIDTH+WGT_WIDTH+log2(LANES)+1 and ≥ PE_OUT_WIDTH.
- PE_OUT_WIDTH, 32: output / partial-sum width.
- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in_valid  in  1  input beat valid.
- mode  in  2  0=MULT, 1=FMA, 2=ACC, 3=reserved (treated as MULT).
- prec_mode  in  1  0=full precision, 1=packed LANES-way.
- acc_clear  in  1  in ACC mode, the beat starts a new accumulation.
- a  in  ACT_WIDTH  activation, two's complement (per lane when packed).
- b  in  WGT_WIDTH  weight, two's complement (per lane when packed).
- c  in  PE_OUT_WIDTH  signed partial sum; used only in FMA.
- out_valid  out  1  result valid.
- out  out  PE_OUT_WIDTH  saturated signed result.
- sat  out  1  out was clipped on this beat.

## Operation
- mode, prec_mode, acc_clear and c are sampled only on in_valid=1 and travel down the pipeline with their beat.
- Stage 1 (product):
  - Full precision: P = signed(a) × signed(b), ACT_WIDTH+WGT_WIDTH bits.
  - Packed: lane i uses a[i·AL +: AL] and b[i·WL +: WL], where AL=ACT_WIDTH/LANES and WL=WGT_WIDTH/LANES.
  - Packed result: P = Σ signed lane products, sign-extended.
- Stage 2 (combine, in ACC_WIDTH two's complement, no wrap checks internally):
  - MULT: S = sext(P).
  - FMA: S = sext(P) + sext(c).
  - ACC: S = (acc_clear ? 0 : acc) + sext(P); acc ← S. The ACC_WIDTH accumulator wraps modulo 2^ACC_WIDTH.
- The accumulator updates only on valid ACC-mode beats. acc_clear is ignored in the other modes, and acc is preserved across them.
- Output:
  - If S > 2^(PE_OUT_WIDTH−1)−1 or S < −2^(PE_OUT_WIDTH−1): out = the clip limit and sat=1.
  - Otherwise out = S[PE_OUT_WIDTH−1:0] and sat=0.
- No backpressure: one beat may be accepted every cycle.
- Back-to-back ACC beats chain correctly because each beat reads the acc written by the previous beat in stage 2.

## Timing
- Latency: a beat accepted at edge N produces out_valid=1 with out/sat after edge N+2, for exactly one cycle per beat.
- Throughput: 1 beat/cycle.
- Bubbles: when in_valid=0, no state changes and out_valid drops to 0 two cycles later. out and sat hold their last values while out_valid=0.
- Reset (reset=0 at an edge):
  - Stage valids, out_valid, out, sat and acc all go to 0.
  - In-flight beats are discarded, including when reset lands mid-stream.
  - The first beat accepted after reset deasserts appears 2 cycles later.
- Simultaneous in_valid=1 and reset=0: reset wins and the beat is dropped.

## Test plan
- MULT, full precision: a=0xFFFD (−3), b=0x0007 → after 2 cycles out=0xFFFFFFEB (−21), sat=0, out_valid high for 1 cycle.
- MULT, packed (LANES=2): a={8'h02,8'hFF}, b={8'h03,8'h05} → out=1 (2·3 + (−1)·5).
- FMA saturation: a=0x7FFF, b=0x7FFF, c=0x7FFFFFFF → out=0x7FFFFFFF, sat=1. The same beat with c=0 gives out=0x3FFF0001, sat=0.
- ACC chain: back-to-back beats (2,3,clear=1), (4,5), (−1,10) → outs 6, 26, 16 on consecutive cycles. Then (1,1,clear=1) → 1.
- Bubbles and mode mixing:
  - Sequence: ACC (3,3,clear) → idle 3 cycles → FMA (1,1,c=100) → ACC (2,2).
  - Required outs: 9, then 101, then 13.
  - out_valid is low during the gaps and out holds 9.
- Reset mid-stream:
  - Stimulus: two ACC beats in flight, then reset=0 for 1 cycle.
  - Required: no out_valid for the dropped beats, out=0, sat=0.
  - Next ACC beat (3,3, clear=0) → 9.
